// File: rtl/wash_pkg.sv
// Shared types and constants for the washer cycle controller.
// Phase encodings double as the debug/display code on the phase port.
package wash_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL1 = 3'd1,
    WASH  = 3'd2,
    FILL2 = 3'd3,
    RINSE = 3'd4,
    SPIN  = 3'd5,
    DRAIN = 3'd6,
    PAUSE = 3'd7
  } state_t;

  localparam logic [1:0] PRESET_USER  = 2'b00;
  localparam logic [1:0] PRESET_RINSE = 2'b01;
  localparam logic [1:0] PRESET_SPIN  = 2'b10;
  localparam logic [1:0] PRESET_DRAIN = 2'b11;

  localparam int FILL_TICKS  = 5;
  localparam int DEF_COUNT_W = 8;

  function automatic logic [1:0] preset_of(
    input state_t s
  );
    logic [1:0] p;
    p = PRESET_USER;
    case (s)
      FILL2, RINSE: p = PRESET_RINSE;
      SPIN:         p = PRESET_SPIN;
      DRAIN:        p = PRESET_DRAIN;
      default:      p = PRESET_USER;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/wash_sequencer_tick_prescaler.sv
// Divides clk down to a one-cycle timer tick every TICK_DIV enabled cycles.
// clr takes priority over en; the count holds whenever en is low.
module tick_prescaler #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/wash_sequencer.sv
// Washer main cycle FSM: owns the phase timer and selects the comparator preset.
// Actuators decode from the registered state; done is a registered pulse.
module wash_sequencer
  import wash_pkg::*;
#(
  parameter int TICK_DIV = 1000,
  parameter int COUNT_W  = DEF_COUNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               door_closed,
  input  logic               comp_time,
  input  logic               comp_time2,
  output logic [COUNT_W-1:0] count,
  output logic [1:0]         control_preset,
  output logic               water_valve,
  output logic               motor_on,
  output logic               motor_spin,
  output logic               door_lock,
  output logic               done,
  output logic [2:0]         phase
);

  state_t state;
  state_t state_nx;
  state_t resume;
  state_t eff;
  logic   phase_change;
  logic   run;
  logic   tick;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start && door_closed) state_nx = FILL1;
      end
      PAUSE: begin
        if (door_closed) state_nx = resume;
      end
      default: begin
        // Door-open wins over any comparator event this cycle
        if (!door_closed) begin
          state_nx = PAUSE;
        end else begin
          case (state)
            FILL1: if (comp_time2) state_nx = WASH;
            WASH:  if (comp_time)  state_nx = FILL2;
            FILL2: if (comp_time2) state_nx = RINSE;
            RINSE: if (comp_time)  state_nx = SPIN;
            SPIN:  if (comp_time)  state_nx = DRAIN;
            DRAIN: if (comp_time)  state_nx = IDLE;
            default: state_nx = state;
          endcase
        end
      end
    endcase
  end

  assign phase_change = (state_nx != state)
                     && (state != PAUSE)
                     && (state_nx != PAUSE);

  assign run = (state != IDLE)
            && (state != PAUSE)
            && door_closed;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  ((state == IDLE) || phase_change),
    .en   (run),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      resume <= IDLE;
      count  <= '0;
      done   <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= (state == DRAIN) && (state_nx == IDLE);
      if ((state_nx == PAUSE) && (state != PAUSE)) begin
        resume <= state;
      end
      if (phase_change) begin
        count <= '0;
      end else if (tick && (count != '1)) begin
        count <= count + 1'b1;
      end
    end
  end

  assign eff = (state == PAUSE) ? resume : state;

  always_comb begin
    control_preset = preset_of(eff);
    water_valve    = (state == FILL1) || (state == FILL2);
    motor_on       = (state == WASH) || (state == RINSE);
    motor_spin     = (state == SPIN);
    door_lock      = (state != IDLE) && (state != PAUSE);
    phase          = state;
  end

endmodule

// File: tb/tb_wash_sequencer.sv
// Self-checking bench for wash_sequencer with a behavioural time comparator.
// Expected phase segments are queued before each cycle and popped on exit.
module tb_wash_sequencer;
  import wash_pkg::*;

  localparam int TD = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          door_closed = 1'b1;
  logic          comp_time;
  logic          comp_time2;
  logic [CW-1:0] count;
  logic [1:0]    control_preset;
  logic          water_valve;
  logic          motor_on;
  logic          motor_spin;
  logic          door_lock;
  logic          done;
  logic [2:0]    phase;
  logic [CW-1:0] washing_time = 8'd8;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [2:0] ph;
    int         len;
    logic [1:0] pre;
    logic [3:0] act;
  } seg_t;

  seg_t exp_q[$];

  always #5 clk = ~clk;

  always_comb begin
    comp_time2 = (count == CW'(FILL_TICKS));
    case (control_preset)
      2'b00:   comp_time = (count == washing_time);
      2'b01:   comp_time = (count == 8'd10);
      2'b10:   comp_time = (count == 8'd16);
      default: comp_time = (count == 8'd21);
    endcase
  end

  wash_sequencer #(
    .TICK_DIV(TD),
    .COUNT_W (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .door_closed   (door_closed),
    .comp_time     (comp_time),
    .comp_time2    (comp_time2),
    .count         (count),
    .control_preset(control_preset),
    .water_valve   (water_valve),
    .motor_on      (motor_on),
    .motor_spin    (motor_spin),
    .door_lock     (door_lock),
    .done          (done),
    .phase         (phase)
  );

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_for(
    input  logic [2:0]    p,
    input  logic [CW-1:0] c,
    output bit            ok
  );
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (phase == p && count == c) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_cycle(
    input logic [CW-1:0] wt,
    input bit            poke
  );
    int         len;
    int         total;
    int         pulses;
    int         want_total;
    logic [2:0] cur;
    logic [1:0] pre;
    logic [3:0] act;
    seg_t       s;
    bit         fin;
    washing_time = wt;
    door_closed  = 1'b1;
    want_total   = TD * (FILL_TICKS * 2 + int'(wt) + 10 + 16 + 21) + 6;
    exp_q.push_back('{FILL1, TD * FILL_TICKS + 1, PRESET_USER, 4'b1001});
    exp_q.push_back('{WASH, TD * int'(wt) + 1, PRESET_USER, 4'b0101});
    exp_q.push_back('{FILL2, TD * FILL_TICKS + 1, PRESET_RINSE, 4'b1001});
    exp_q.push_back('{RINSE, TD * 10 + 1, PRESET_RINSE, 4'b0101});
    exp_q.push_back('{SPIN, TD * 16 + 1, PRESET_SPIN, 4'b0011});
    exp_q.push_back('{DRAIN, TD * 21 + 1, PRESET_DRAIN, 4'b0001});
    pulse_start();
    cur    = phase;
    pre    = control_preset;
    act    = {water_valve, motor_on, motor_spin, door_lock};
    len    = 1;
    total  = 1;
    pulses = 0;
    fin    = 1'b0;
    for (int i = 0; i < 2000 && !fin; i++) begin
      @(negedge clk);
      start = poke && (phase == SPIN);
      if (done) pulses++;
      if (phase != cur) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL seg_extra: got phase %0d want none", cur);
        end else begin
          s = exp_q.pop_front();
          if (cur !== s.ph) begin
            miscompares++;
            $display("FAIL seg_phase: got %0d want %0d", cur, s.ph);
          end
          vectors++;
          if (len !== s.len) begin
            miscompares++;
            $display("FAIL seg_len ph%0d: got %0d want %0d",
                     s.ph, len, s.len);
          end
          vectors++;
          if (pre !== s.pre) begin
            miscompares++;
            $display("FAIL seg_preset ph%0d: got %b want %b",
                     s.ph, pre, s.pre);
          end
          vectors++;
          if (act !== s.act) begin
            miscompares++;
            $display("FAIL seg_act ph%0d: got %b want %b",
                     s.ph, act, s.act);
          end
        end
        cur = phase;
        pre = control_preset;
        act = {water_valve, motor_on, motor_spin, door_lock};
        len = 1;
        if (cur == IDLE) fin = 1'b1;
      end else begin
        len++;
      end
      if (phase != IDLE) total++;
    end
    start = 1'b0;
    vectors++;
    if (!fin) begin
      miscompares++;
      $display("FAIL cycle_timeout: got phase %0d want %0d", phase, IDLE);
    end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL done_edge: got %b want 1", done);
    end
    vectors++;
    if (total !== want_total) begin
      miscompares++;
      $display("FAIL cycle_len: got %0d want %0d", total, want_total);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL seg_left: got %0d want 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    if (done) pulses++;
    vectors++;
    if (pulses !== 1) begin
      miscompares++;
      $display("FAIL done_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (phase !== IDLE || count !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got ph%0d cnt%0d want ph0 cnt0",
               phase, count);
    end
    vectors++;
    if ({water_valve, motor_on, motor_spin, door_lock, done,
         control_preset} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_outs: got %b want 0",
               {water_valve, motor_on, motor_spin, door_lock, done,
                control_preset});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_cycle();
    run_cycle(8'd8, 1'b0);
  endtask

  task automatic test_start_ignored();
    door_closed = 1'b0;
    start = 1'b1;
    repeat (4) @(negedge clk);
    start = 1'b0;
    vectors++;
    if (phase !== IDLE || door_lock !== 1'b0) begin
      miscompares++;
      $display("FAIL start_door_open: got ph%0d lock%b want ph0 lock0",
               phase, door_lock);
    end
    door_closed = 1'b1;
    @(negedge clk);
    run_cycle(8'd5, 1'b1);
  endtask

  task automatic test_reset_mid_wash();
    bit ok;
    washing_time = 8'd8;
    pulse_start();
    wait_for(WASH, 8'd3, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL rst_reach_wash: got ph%0d cnt%0d want ph2 cnt3",
               phase, count);
    end
    do_reset();
    vectors++;
    if (phase !== IDLE || count !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_state: got ph%0d cnt%0d want ph0 cnt0",
               phase, count);
    end
    vectors++;
    if ({water_valve, motor_on, motor_spin, door_lock, done}
        !== 5'b0) begin
      miscompares++;
      $display("FAIL rst_mid_outs: got %b want 00000",
               {water_valve, motor_on, motor_spin, door_lock, done});
    end
    @(negedge clk);
    vectors++;
    if (phase !== IDLE || done !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_hold: got ph%0d done%b want ph0 done0",
               phase, done);
    end
  endtask

  task automatic test_pause_resume();
    bit ok;
    int n;
    washing_time = 8'd8;
    pulse_start();
    wait_for(WASH, 8'd4, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL pause_reach: got ph%0d cnt%0d want ph2 cnt4",
               phase, count);
    end
    door_closed = 1'b0;
    @(negedge clk);
    vectors++;
    if (phase !== PAUSE || door_lock !== 1'b0 || motor_on !== 1'b0) begin
      miscompares++;
      $display("FAIL pause_enter: got ph%0d lock%b mot%b want ph7 0 0",
               phase, door_lock, motor_on);
    end
    repeat (6) @(negedge clk);
    vectors++;
    if (phase !== PAUSE || count !== 8'd4 || control_preset !== 2'b00) begin
      miscompares++;
      $display("FAIL pause_hold: got ph%0d cnt%0d pre%b want ph7 4 00",
               phase, count, control_preset);
    end
    door_closed = 1'b1;
    @(negedge clk);
    vectors++;
    if (phase !== WASH || count !== 8'd4 || motor_on !== 1'b1) begin
      miscompares++;
      $display("FAIL pause_resume: got ph%0d cnt%0d mot%b want ph2 4 1",
               phase, count, motor_on);
    end
    n = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (phase != WASH) break;
      n++;
    end
    vectors++;
    if (n !== TD * 4 + 1) begin
      miscompares++;
      $display("FAIL pause_rest_len: got %0d want %0d", n, TD * 4 + 1);
    end
    vectors++;
    if (phase !== FILL2 || count !== '0) begin
      miscompares++;
      $display("FAIL pause_next: got ph%0d cnt%0d want ph3 cnt0",
               phase, count);
    end
    do_reset();
  endtask

  task automatic test_door_race();
    bit ok;
    washing_time = 8'd0;
    pulse_start();
    wait_for(RINSE, 8'd10, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL race_reach: got ph%0d cnt%0d want ph4 cnt10",
               phase, count);
    end
    door_closed = 1'b0;
    @(negedge clk);
    vectors++;
    if (phase !== PAUSE || count !== 8'd10 || control_preset !== 2'b01) begin
      miscompares++;
      $display("FAIL race_pause: got ph%0d cnt%0d pre%b want ph7 10 01",
               phase, count, control_preset);
    end
    @(negedge clk);
    door_closed = 1'b1;
    @(negedge clk);
    vectors++;
    if (phase !== RINSE || count !== 8'd10 || door_lock !== 1'b1) begin
      miscompares++;
      $display("FAIL race_resume: got ph%0d cnt%0d lock%b want ph4 10 1",
               phase, count, door_lock);
    end
    @(negedge clk);
    vectors++;
    if (phase !== SPIN || count !== '0 || control_preset !== 2'b10) begin
      miscompares++;
      $display("FAIL race_exit: got ph%0d cnt%0d pre%b want ph5 0 10",
               phase, count, control_preset);
    end
    do_reset();
  endtask

  task automatic test_zero_wash();
    run_cycle(8'd0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_full_cycle();
    test_start_ignored();
    test_reset_mid_wash();
    test_pause_resume();
    test_door_race();
    test_zero_wash();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wash_sequencer.md
Name: wash_sequencer

Overview:
Main cycle controller for the washer. It owns the phase timer `count` and selects `control_preset` for the downstream time comparator. It consumes `comp_time` (phase target reached) and `comp_time2` (count==5, fill complete) back from that comparator. It drives the valve, motor, lock and done outputs.

Parameters:
- TICK_DIV, 1000, clk cycles per timer tick; minimum 2.
- COUNT_W, 8, width of `count`; must match the comparator.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- start  in  1  level; starts a cycle from IDLE
- door_closed  in  1  1 = door shut
- comp_time  in  1  comparator: count equals the target for the current preset
- comp_time2  in  1  comparator: count == 5
- count  out  COUNT_W  phase timer, feeds the comparator
- control_preset  out  2  00 = user washing_time, 01 = 10 ticks, 10 = 16 ticks, 11 = 21 ticks
- water_valve  out  1  fill valve open
- motor_on  out  1  drum agitate
- motor_spin  out  1  high-speed spin
- door_lock  out  1  door latch engaged
- done  out  1  one-cycle pulse at end of cycle
- phase  out  3  current state encoding (debug/display)

Behaviour:
Reset:
- While rst_n=0 at a rising edge: state=IDLE, count=0, control_preset=00, prescaler=0.
- All other outputs 0.
- Reset overrides everything, including mid-phase; no completion pulse is issued.

Tick generation:
- Prescaler counts 0..TICK_DIV-1 in every non-IDLE state while door_closed=1.
- tick=1 for one clk cycle when the prescaler equals TICK_DIV-1; prescaler then wraps to 0.
- Prescaler is held while the door is open and cleared in IDLE.

States and Moore outputs (outputs are registered, or decoded from the registered state):
- IDLE: preset 00, all actuators 0.
- FILL1: preset 00, water_valve=1, door_lock=1.
- WASH: preset 00, motor_on=1, door_lock=1.
- FILL2: preset 01, water_valve=1, door_lock=1.
- RINSE: preset 01, motor_on=1, door_lock=1.
- SPIN: preset 10, motor_spin=1, door_lock=1.
- DRAIN: preset 11, door_lock=1.
- PAUSE: preset held, door_lock=0, actuators 0; remembers the resume state.

Transitions (evaluated every clk):
- IDLE -> FILL1 when start=1 and door_closed=1. start with the door open is ignored.
- FILL1 -> WASH when comp_time2=1.
- WASH -> FILL2 when comp_time=1.
- FILL2 -> RINSE when comp_time2=1.
- RINSE -> SPIN when comp_time=1.
- SPIN -> DRAIN when comp_time=1.
- DRAIN -> IDLE when comp_time=1; done=1 on that same edge, for one cycle.
- Any active state -> PAUSE when door_closed=0. Door-open takes priority over a simultaneous comp event.
- PAUSE -> saved state when door_closed=1. No tick in the resume cycle.

Counter rules:
- count clears to 0 on every phase-to-phase transition.
- Otherwise count increments by 1 on tick.
- count holds in PAUSE and IDLE.
- count saturates at 2^COUNT_W-1; it never wraps.

Comparator interaction:
- comp_time/comp_time2 are combinational from the current count and control_preset.
- A phase therefore exits in the clk cycle after count reaches its target.
- Phase length = target ticks plus at most one clk.
- washing_time=0: comp_time is already 1 on WASH entry, so WASH lasts exactly one clk cycle.
- Comparator inputs in FILL phases are ignored except comp_time2.
- comp_time2 is ignored outside FILL phases.

Other rules:
- start is ignored outside IDLE.
- done never coincides with reset.

Decomposition:
- Package wash_pkg:
  - state enum: IDLE, FILL1, WASH, FILL2, RINSE, SPIN, DRAIN, PAUSE.
  - preset constants: PRESET_USER=2'b00, PRESET_RINSE=2'b01, PRESET_SPIN=2'b10, PRESET_DRAIN=2'b11.
  - FILL_TICKS=5.
  - COUNT_W default.
- Sub-module tick_prescaler:
  - Parameter TICK_DIV.
  - Inputs: clk, rst_n, clr, en.
  - Output: tick.
- FSM and counter stay in wash_sequencer.

Test Plan:
Bench uses TICK_DIV=4 and a behavioural model of the comparator (targets: washing_time, 10, 16, 21; comp_time2 at count 5).
1. Reset mid-WASH (count=3) with rst_n=0 for one edge -> next cycle state=IDLE, count=0, all actuators 0, done=0.
2. Full cycle: door_closed=1, washing_time=8, start pulse -> phases FILL1(5), WASH(8), FILL2(5), RINSE(10), SPIN(16), DRAIN(21) ticks, each +1 clk. done pulses once at 65 ticks ×4 clk plus 6 transition clks.
3. door_closed=0 at WASH count=4 -> PAUSE, door_lock=0, motor_on=0, count stays 4. door_closed=1 -> WASH resumes and exits after 4 more ticks.
4. Door opens in the same cycle comp_time=1 in RINSE -> PAUSE (not SPIN). On close -> RINSE, count=10, exits next clk.
5. washing_time=0 -> WASH lasts exactly one clk; FILL2 entered with count=0.
6. start=1 with door_closed=0 -> stays IDLE. start pulses during SPIN -> no effect. control_preset equals the table value in every phase.
